// File: rtl/mux_32_pkg.sv
// Shared constants for the 32-to-1 datapath mux: select width and the
// heap numbering used to lay out the binary selection tree.
package mux_32_pkg;
    localparam int SEL_W     = 5;
    localparam int NUM_IN    = 32;
    localparam int LEAF_BASE = NUM_IN;

    // Tree nodes use heap numbering: 1 is the root, node i feeds from 2i and
    // 2i+1, leaves are 32..63. Root uses select[4], leaf-level muxes select[0].
    function automatic int node_sel_bit(input int node);
        return SEL_W - $clog2(node + 1);
    endfunction
endpackage

// File: rtl/mux_32_mux2.sv
// N-bit 2:1 mux, the building block of the mux_32 selection tree.
module mux2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sel,
    output logic [N-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/mux_32.sv
// N-bit 32-to-1 mux built as a 5-level tree of mux2, with a registered copy
// of the selected word for pipelined consumers.
module mux_32
    import mux_32_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in00, in01, in02, in03, in04, in05, in06, in07,
    input  logic [N-1:0]     in08, in09, in10, in11, in12, in13, in14, in15,
    input  logic [N-1:0]     in16, in17, in18, in19, in20, in21, in22, in23,
    input  logic [N-1:0]     in24, in25, in26, in27, in28, in29, in30, in31,
    input  logic [SEL_W-1:0] select,
    output logic [N-1:0]     out,
    output logic [N-1:0]     out_q
);
    logic [N-1:0] w_node [1:2*NUM_IN-1];
    logic [N-1:0] r_out_q;

    assign w_node[32] = in00; assign w_node[33] = in01; assign w_node[34] = in02; assign w_node[35] = in03;
    assign w_node[36] = in04; assign w_node[37] = in05; assign w_node[38] = in06; assign w_node[39] = in07;
    assign w_node[40] = in08; assign w_node[41] = in09; assign w_node[42] = in10; assign w_node[43] = in11;
    assign w_node[44] = in12; assign w_node[45] = in13; assign w_node[46] = in14; assign w_node[47] = in15;
    assign w_node[48] = in16; assign w_node[49] = in17; assign w_node[50] = in18; assign w_node[51] = in19;
    assign w_node[52] = in20; assign w_node[53] = in21; assign w_node[54] = in22; assign w_node[55] = in23;
    assign w_node[56] = in24; assign w_node[57] = in25; assign w_node[58] = in26; assign w_node[59] = in27;
    assign w_node[60] = in28; assign w_node[61] = in29; assign w_node[62] = in30; assign w_node[63] = in31;

    for (genvar i = 1; i < LEAF_BASE; i++) begin : g_tree
        localparam int SB = node_sel_bit(i);
        mux2 #(.N(N)) u_mux2 (
            .i_a   (w_node[2*i]),
            .i_b   (w_node[2*i+1]),
            .i_sel (select[SB]),
            .o_y   (w_node[i])
        );
    end

    assign out = w_node[1];

    always_ff @(posedge clk) begin
        if (rst) r_out_q <= '0;
        else     r_out_q <= w_node[1];
    end

    assign out_q = r_out_q;
endmodule

// File: tb/tb_mux_32.sv
// Scoreboard bench for mux_32: stimulus pushes expected words, a monitor
// pops and compares against out / out_q.
module tb_mux_32;
    localparam int N = 32;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          reg_path;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  tb_in [32];
    logic [4:0]    tb_sel = '0;
    logic [N-1:0]  out, out_q;

    exp_t   sb_q[$];
    event   ev_sample;
    int     n_tests = 0;
    int     n_fail  = 0;

    mux_32 #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in00(tb_in[0]),  .in01(tb_in[1]),  .in02(tb_in[2]),  .in03(tb_in[3]),
        .in04(tb_in[4]),  .in05(tb_in[5]),  .in06(tb_in[6]),  .in07(tb_in[7]),
        .in08(tb_in[8]),  .in09(tb_in[9]),  .in10(tb_in[10]), .in11(tb_in[11]),
        .in12(tb_in[12]), .in13(tb_in[13]), .in14(tb_in[14]), .in15(tb_in[15]),
        .in16(tb_in[16]), .in17(tb_in[17]), .in18(tb_in[18]), .in19(tb_in[19]),
        .in20(tb_in[20]), .in21(tb_in[21]), .in22(tb_in[22]), .in23(tb_in[23]),
        .in24(tb_in[24]), .in25(tb_in[25]), .in26(tb_in[26]), .in27(tb_in[27]),
        .in28(tb_in[28]), .in29(tb_in[29]), .in30(tb_in[30]), .in31(tb_in[31]),
        .select(tb_sel), .out(out), .out_q(out_q)
    );

    always #5 clk = ~clk;

    // Reference: the selected word is simply the array element at select.
    function automatic logic [31:0] ref_mux();
        return tb_in[tb_sel];
    endfunction

    task automatic check_comb(input string name);
        sb_q.push_back('{name, ref_mux(), 1'b0});
        -> ev_sample;
        #2;
    endtask

    // Expected out_q is fixed by pre-edge state; checked 1 ns after the edge.
    task automatic clk_step(input string name);
        logic [31:0] e;
        e = rst ? 32'd0 : ref_mux();
        @(posedge clk);
        sb_q.push_back('{name, e, 1'b1});
        -> ev_sample;
        #2;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(ev_sample);
            #1;
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = e.reg_path ? out_q : out;
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int k = 0; k < 32; k++) tb_in[k] = 32'(k);
        #12;

        rst = 1'b1;
        clk_step("reset_outq");
        check_comb("reset_out_passthru");
        rst = 1'b0;

        for (int s = 0; s < 32; s++) begin
            tb_sel = 5'(s);
            #1;
            check_comb($sformatf("sweep_sel%0d", s));
        end

        @(negedge clk); tb_sel = 5'd17; clk_step("reg_sel17");
        @(negedge clk); tb_sel = 5'd3;  clk_step("reg_sel3");

        @(negedge clk); tb_sel = 5'd17; clk_step("pre_reset_q17");
        @(negedge clk); rst = 1'b1;     clk_step("midreset_q0");
        check_comb("midreset_out");
        @(negedge clk); rst = 1'b0;     clk_step("post_reset_reload");

        @(negedge clk); tb_sel = 5'd31; tb_in[31] = 32'd5;
        #1; check_comb("data_change_out");
        clk_step("data_change_q");

        @(negedge clk); tb_sel = 5'd0; tb_in[0] = 32'd0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 1; k < 32; k++) tb_in[k] = (r == 0) ? 'x : $urandom;
            #1; check_comb($sformatf("isolation_%0d", r));
        end

        tb_in[0] = 32'hFFFF_FFFF; tb_in[31] = 32'hA5A5_5A5A;
        tb_sel = 5'd0;  #1; check_comb("fullwidth_sel0");
        tb_sel = 5'd31; #1; check_comb("fullwidth_sel31");

        for (int r = 0; r < 200; r++) begin
            @(negedge clk);
            for (int k = 0; k < 32; k++) tb_in[k] = $urandom;
            tb_sel = 5'($urandom_range(0, 31));
            rst    = ($urandom_range(0, 9) == 0);
            #1; check_comb($sformatf("rand_out_%0d", r));
            clk_step($sformatf("rand_q_%0d", r));
        end
        rst = 1'b0;

        #5;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_32.md
# mux_32

N-bit, 32-to-1 multiplexer for the datapath (register-file read port, ALU result select). Data is selected combinationally by a 5-bit select. A registered copy of the selected word is also provided for pipelined consumers. The block holds no other state.

## Interface

- N, default 32: width in bits of every data input and both outputs.
- clk  input  1  rising-edge clock; used only by the registered output.
- rst  input  1  synchronous, active-high reset.
- in00 … in31  input  N each  32 data words; index equals select value.
- select  input  5  binary index of the word to pass.
- out  output  N  combinational selected word.
- out_q  output  N  registered selected word.

Port order: clk, rst, in00 … in31, select, out, out_q.

## Operation

- out = in<select> for every select value 0…31; binary encoding, in00 at 0, in31 at 31.
- Every 5-bit select value is valid; there are no unused codes and no default/X output.
- out follows any change on select or on the currently selected input, with no clock involvement.
- Data passes unmodified: no sign extension, truncation or arithmetic. All inputs are exactly N bits.
- out_q captures out on each rising clk edge when rst = 0.
- out_q loads all-zero on a rising clk edge when rst = 1. rst has no effect on out.
- Unknown or high-Z values on non-selected inputs must not affect out.

## Timing

- out: zero-cycle latency, purely combinational from select and in00–in31. It must be valid within the same delta/settling window (a bench sampling 1 ns after a change sees the new value).
- out_q: one-cycle latency. The value present on out just before edge k appears on out_q after edge k.
- Reset value: out_q = 0 after the first rising edge with rst high. out has no reset value; it always reflects its inputs.
- Reset mid-operation: rst wins on that edge (out_q = 0). Selection resumes on the next edge with rst low.
- select changing on the same edge as the clock: out_q captures the pre-edge select's word.
- No handshake, enable or state machine.

## Structure

- No package types required. N is a module parameter; the select width (5) is fixed.
- Natural sub-module: mux2 (N-bit 2:1, parameter N). Build mux_32 as a 5-level binary tree of 31 mux2 instances. select[0] drives the leaf level and select[4] drives the root.
- A flat case statement is an acceptable equivalent implementation.
- out_q is a single N-bit always_ff register in mux_32, not inside mux2.

## Test plan

- Sweep: in_k = k (k = 0…31), N = 5, select stepped 0→31 with a 1 ns wait each step. Expect out = select at each step (0, 1, …, 31).
- Registered path: same inputs, rst = 0. Apply select = 17, one clk edge → out_q = 17. Then select = 3, next edge → out_q = 3.
- Reset: out_q = 17, then assert rst for one edge → out_q = 0 while out still equals in<select>. Deassert rst, next edge → out_q reloads.
- Data change on selected input: select = 31, in31 changes 31 → 5. Expect out = 5 immediately, out_q = 5 after the next edge.
- Isolation: select = 0, toggle in01…in31 (including X values). Expect out stays = in00 = 0.
- Full width: N = 32, in00 = 0xFFFF_FFFF, in31 = 0xA5A5_5A5A. Expect select 0 → 0xFFFF_FFFF and select 31 → 0xA5A5_5A5A, with no truncation.
